// File: rtl/can_rx_crc_ctrl_pkg.sv
// can_pkg: shared constants, field-state encoding and a data-length helper
// for the CAN receive-path CRC sequencer.
package can_pkg;

   localparam int CRC_W          = 15;
   localparam int MAX_DATA_BYTES = 8;

   localparam int SOF_ARB_BITS  = 13;
   localparam int CTRL_BITS     = 6;
   localparam int EXT_BITS      = 20;
   localparam int MAX_DATA_BITS = 64;

   localparam logic [2:0] FLD_IDLE    = 3'd0;
   localparam logic [2:0] FLD_SOF_ARB = 3'd1;
   localparam logic [2:0] FLD_CTRL    = 3'd2;
   localparam logic [2:0] FLD_DATA    = 3'd3;
   localparam logic [2:0] FLD_CRC     = 3'd4;
   localparam logic [2:0] FLD_DELIM   = 3'd5;
   localparam logic [2:0] FLD_ARB_EXT = 3'd6;

   typedef enum logic [2:0] {
      ST_IDLE    = FLD_IDLE,
      ST_SOF_ARB = FLD_SOF_ARB,
      ST_CTRL    = FLD_CTRL,
      ST_DATA    = FLD_DATA,
      ST_CRC     = FLD_CRC,
      ST_DELIM   = FLD_DELIM,
      ST_ARB_EXT = FLD_ARB_EXT
   } field_e;

   // Number of data-field bits for a frame: none for remote frames,
   // otherwise 8 per byte with DLC values above max_bytes saturating.
   function automatic logic [6:0] calc_data_bits(logic rtr, logic [3:0] dlc, int max_bytes);
      int n;
      n = (int'(dlc) > max_bytes) ? max_bytes : int'(dlc);
      if (rtr) n = 0;
      return 7'(n * 8);
   endfunction

endpackage

// File: rtl/can_rx_crc_ctrl_cmp.sv
// can_crc_cmp: captures the received CRC field (MSB first) and compares it
// with the CRC core result when the delimiter arrives.
module can_crc_cmp #(
   parameter int CRC_W = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_shift,
   input  logic             i_bit,
   input  logic             i_cmp,
   input  logic [CRC_W-1:0] i_crc_in,
   output logic             o_crc_ok,
   output logic             o_crc_err
);

   logic [CRC_W-1:0] r_cap;

   // Capture register and one-clk result pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cap     <= '0;
         o_crc_ok  <= 1'b0;
         o_crc_err <= 1'b0;
      end else begin
         if (i_shift) r_cap <= {r_cap[CRC_W-2:0], i_bit};
         o_crc_ok  <= i_cmp & (r_cap == i_crc_in);
         o_crc_err <= i_cmp & (r_cap != i_crc_in);
      end
   end

endmodule

// File: rtl/can_rx_crc_ctrl.sv
// can_rx_crc_ctrl: follows CAN frame fields on the destuffed receive stream,
// feeds SOF..data bits to the external CRC-15 core and checks the received CRC.
// Optional macro CAN_EXT_ID_EN adds extended-identifier (ARB_EXT) handling.
//
//   state      | meaning
//   IDLE    (0)| bus idle, waiting for a dominant SOF; CRC core held clear
//   SOF_ARB (1)| SOF + 11 ID bits + RTR/SRR
//   CTRL    (2)| IDE, r0, DLC[3:0]
//   DATA    (3)| data-field bits
//   CRC     (4)| 15 received CRC bits captured, core frozen
//   DELIM   (5)| CRC delimiter, result reported here
//   ARB_EXT (6)| 18 extended ID bits + RTR + r1 (option)
module can_rx_crc_ctrl #(
   parameter int CRC_W          = can_pkg::CRC_W,
   parameter int MAX_DATA_BYTES = can_pkg::MAX_DATA_BYTES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_rx_bit,
   input  logic             i_rx_bit_valid,
   input  logic             i_rx_stuff,
   input  logic             i_rx_abort,
   input  logic [CRC_W-1:0] i_crc_in,
   output logic             o_crc_din,
   output logic             o_crc_en,
   output logic             o_crc_clr,
   output logic             o_busy,
   output logic [2:0]       o_field,
   output logic [3:0]       o_dlc,
   output logic             o_rtr,
   output logic             o_crc_ok,
   output logic             o_crc_err,
   output logic             o_form_err
);
   import can_pkg::*;

   field_e     r_state;
   logic [6:0] r_bit_cnt;
   logic [6:0] r_data_bits;

   logic       w_acc;
   logic       w_crc_state;
   logic [6:0] w_data_bits;

   assign w_acc       = i_rx_bit_valid & ~i_rx_stuff & ~i_rx_abort;
   // Bits that go through the LFSR: SOF (dominant bit seen in IDLE) through the data field.
   assign w_crc_state = (r_state == ST_SOF_ARB) || (r_state == ST_CTRL) ||
                        (r_state == ST_DATA) || (r_state == ST_ARB_EXT) ||
                        ((r_state == ST_IDLE) && !i_rx_bit);
   assign w_data_bits = calc_data_bits(o_rtr, {o_dlc[2:0], i_rx_bit}, MAX_DATA_BYTES);

   assign o_busy  = (r_state != ST_IDLE);
   assign o_field = r_state;

   // Frame field sequencer with registered CRC-core controls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_bit_cnt   <= '0;
         r_data_bits <= '0;
         o_dlc       <= '0;
         o_rtr       <= 1'b0;
         o_crc_en    <= 1'b0;
         o_crc_din   <= 1'b0;
         o_crc_clr   <= 1'b1;
         o_form_err  <= 1'b0;
      end else begin
         o_crc_en   <= w_acc & w_crc_state;
         o_crc_din  <= w_acc & w_crc_state & i_rx_bit;
         o_form_err <= 1'b0;
         if (i_rx_abort) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            o_crc_clr <= 1'b1;
         end else if (w_acc) begin
            case (r_state)
               ST_IDLE: begin
                  if (!i_rx_bit) begin
                     r_state   <= ST_SOF_ARB;
                     r_bit_cnt <= 7'd1;
                     o_crc_clr <= 1'b0;
                  end
               end
               ST_SOF_ARB: begin
                  if (r_bit_cnt == 7'(SOF_ARB_BITS - 1)) begin
                     o_rtr     <= i_rx_bit;
                     r_state   <= ST_CTRL;
                     r_bit_cnt <= '0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 7'd1;
                  end
               end
               ST_CTRL: begin
                  if ((r_bit_cnt == 7'd0) && i_rx_bit) begin
`ifdef CAN_EXT_ID_EN
                     r_state   <= ST_ARB_EXT;
                     r_bit_cnt <= '0;
`else
                     o_form_err <= 1'b1;
                     r_state    <= ST_IDLE;
                     r_bit_cnt  <= '0;
                     o_crc_clr  <= 1'b1;
`endif
                  end else if (r_bit_cnt == 7'(CTRL_BITS - 1)) begin
                     o_dlc       <= {o_dlc[2:0], i_rx_bit};
                     r_data_bits <= w_data_bits;
                     r_bit_cnt   <= '0;
                     r_state     <= (w_data_bits == 7'd0) ? ST_CRC : ST_DATA;
                  end else begin
                     if (r_bit_cnt >= 7'd2) o_dlc <= {o_dlc[2:0], i_rx_bit};
                     r_bit_cnt <= r_bit_cnt + 7'd1;
                  end
               end
`ifdef CAN_EXT_ID_EN
               ST_ARB_EXT: begin
                  if (r_bit_cnt == 7'(EXT_BITS - 2)) o_rtr <= i_rx_bit;
                  if (r_bit_cnt == 7'(EXT_BITS - 1)) begin
                     // IDE already consumed; resume CTRL at r0.
                     r_state   <= ST_CTRL;
                     r_bit_cnt <= 7'd1;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 7'd1;
                  end
               end
`endif
               ST_DATA: begin
                  if (r_bit_cnt == r_data_bits - 7'd1) begin
                     r_state   <= ST_CRC;
                     r_bit_cnt <= '0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 7'd1;
                  end
               end
               ST_CRC: begin
                  if (r_bit_cnt == 7'(CRC_W - 1)) begin
                     r_state   <= ST_DELIM;
                     r_bit_cnt <= '0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 7'd1;
                  end
               end
               ST_DELIM: begin
                  o_form_err <= ~i_rx_bit;
                  r_state    <= ST_IDLE;
                  r_bit_cnt  <= '0;
                  o_crc_clr  <= 1'b1;
               end
               default: begin
                  r_state   <= ST_IDLE;
                  r_bit_cnt <= '0;
                  o_crc_clr <= 1'b1;
               end
            endcase
         end
      end
   end

   can_crc_cmp #(.CRC_W(CRC_W)) u_cmp (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_shift   (w_acc && (r_state == ST_CRC)),
      .i_bit     (i_rx_bit),
      .i_cmp     (w_acc && (r_state == ST_DELIM) && i_rx_bit),
      .i_crc_in  (i_crc_in),
      .o_crc_ok  (o_crc_ok),
      .o_crc_err (o_crc_err)
   );

endmodule

// File: tb/tb_can_rx_crc_ctrl.sv
// Testbench for can_rx_crc_ctrl: builds CAN frames from their field layout,
// stuffs them, and checks result pulses through a scoreboard.
module tb_can_rx_crc_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_rx_bit = 1'b1;
   logic        i_rx_bit_valid = 1'b0;
   logic        i_rx_stuff = 1'b0;
   logic        i_rx_abort = 1'b0;
   logic [14:0] core_crc;
   logic        o_crc_din, o_crc_en, o_crc_clr, o_busy, o_rtr;
   logic        o_crc_ok, o_crc_err, o_form_err;
   logic [2:0]  o_field;
   logic [3:0]  o_dlc;

   always #5 clk = ~clk;

   can_rx_crc_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_rx_bit       (i_rx_bit),
      .i_rx_bit_valid (i_rx_bit_valid),
      .i_rx_stuff     (i_rx_stuff),
      .i_rx_abort     (i_rx_abort),
      .i_crc_in       (core_crc),
      .o_crc_din      (o_crc_din),
      .o_crc_en       (o_crc_en),
      .o_crc_clr      (o_crc_clr),
      .o_busy         (o_busy),
      .o_field        (o_field),
      .o_dlc          (o_dlc),
      .o_rtr          (o_rtr),
      .o_crc_ok       (o_crc_ok),
      .o_crc_err      (o_crc_err),
      .o_form_err     (o_form_err)
   );

   // CAN CRC-15 definition (polynomial 0x4599).
   function automatic logic [14:0] crc_step(logic [14:0] c, logic b);
      logic [14:0] n;
      n = {c[13:0], 1'b0};
      if (b ^ c[14]) n = n ^ 15'h4599;
      return n;
   endfunction

   // Stand-in for the external CRC core.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)         core_crc <= '0;
      else if (o_crc_clr) core_crc <= '0;
      else if (o_crc_en)  core_crc <= crc_step(core_crc, o_crc_din);
   end

   typedef struct {
      logic [2:0]  kind;     // {form, err, ok}
      int          en_cnt;
      logic [3:0]  dlc;
      logic        rtr;
      bit          chk_dlc;
   } exp_t;

   exp_t       sb[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         mon_en = 0;
   bit         fb[$];
   logic [2:0] ff[$];

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: counts crc_en pulses per frame and scores every result pulse.
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_crc_en) mon_en++;
         if (o_crc_ok | o_crc_err | o_form_err) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", longint'({o_form_err, o_crc_err, o_crc_ok}), 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("result_kind", longint'({o_form_err, o_crc_err, o_crc_ok}), longint'(e.kind));
               chk("crc_en_count", longint'(mon_en), longint'(e.en_cnt));
               if (e.chk_dlc) begin
                  chk("dlc", longint'(o_dlc), longint'(e.dlc));
                  chk("rtr", longint'(o_rtr), longint'(e.rtr));
               end
            end
         end
         if (o_crc_clr) mon_en = 0;
      end
   end

   task automatic add(input bit b, input logic [2:0] f);
      fb.push_back(b);
      ff.push_back(f);
   endtask

   // Frame bits with the field code expected after each bit is accepted.
   task automatic build_std(input logic [10:0] id, input bit rtr, input logic [3:0] dlc,
                            input logic [63:0] data, input logic [14:0] flip,
                            input bit delim, output exp_t e);
      int nd;
      logic [14:0] c;
      fb.delete();
      ff.delete();
      add(1'b0, 3'd1);
      for (int i = 10; i >= 0; i--) add(id[i], 3'd1);
      add(rtr, 3'd2);
      add(1'b0, 3'd2);
      add(1'b0, 3'd2);
      nd = rtr ? 0 : 8 * ((dlc > 4'd8) ? 8 : int'(dlc));
      for (int i = 3; i >= 0; i--) add(dlc[i], (i != 0) ? 3'd2 : ((nd != 0) ? 3'd3 : 3'd4));
      for (int k = 0; k < nd; k++) add(data[63-k], (k == nd - 1) ? 3'd4 : 3'd3);
      c = '0;
      foreach (fb[i]) c = crc_step(c, fb[i]);
      e.en_cnt = fb.size();
      c = c ^ flip;
      for (int i = 14; i >= 0; i--) add(c[i], (i == 0) ? 3'd5 : 3'd4);
      add(delim, 3'd0);
      e.kind    = !delim ? 3'b100 : ((flip != 0) ? 3'b010 : 3'b001);
      e.dlc     = dlc;
      e.rtr     = rtr;
      e.chk_dlc = 1'b1;
   endtask

   task automatic strobe(input bit b, input bit s, input bit ab);
      repeat (2) @(posedge clk);
      #1;
      i_rx_bit = b;
      i_rx_stuff = s;
      i_rx_abort = ab;
      i_rx_bit_valid = 1'b1;
      @(posedge clk);
      #1;
      i_rx_bit_valid = 1'b0;
      i_rx_stuff = 1'b0;
      i_rx_abort = 1'b0;
      i_rx_bit = 1'b1;
   endtask

   // Sends fb[] with bit stuffing up to the end of the CRC field.
   task automatic send_frame(input int abort_at);
      bit last;
      int run;
      run = 0;
      last = 1'b0;
      for (int i = 0; i < fb.size(); i++) begin
         if (i == abort_at) begin
            strobe(fb[i], 1'b0, 1'b1);
            chk("abort_field", longint'(o_field), 0);
            chk("abort_crc_clr", longint'(o_crc_clr), 1);
            chk("abort_busy", longint'(o_busy), 0);
            return;
         end
         strobe(fb[i], 1'b0, 1'b0);
         chk("field_after_bit", longint'(o_field), longint'(ff[i]));
         if (i < fb.size() - 1) begin
            if (run > 0 && fb[i] == last) run++;
            else run = 1;
            last = fb[i];
            if (run == 5) begin
               strobe(!last, 1'b1, 1'b0);
               last = !last;
               run = 1;
            end
         end
      end
      repeat ($urandom_range(1, 6)) @(posedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      #12;
      chk("rst_field", longint'(o_field), 0);
      chk("rst_crc_clr", longint'(o_crc_clr), 1);
      chk("rst_busy", longint'(o_busy), 0);
      chk("rst_crc_en", longint'(o_crc_en), 0);
      chk("rst_results", longint'({o_crc_ok, o_crc_err, o_form_err}), 0);
      chk("rst_dlc_rtr", longint'({o_dlc, o_rtr}), 0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      strobe(1'b0, 1'b1, 1'b0);
      chk("idle_stuff_ignored", longint'(o_field), 0);

      build_std(11'h000, 1'b0, 4'd0, 64'h0, 15'h0000, 1'b1, e);
      sb.push_back(e);
      send_frame(-1);

      build_std(11'h000, 1'b0, 4'd0, 64'h0, 15'h0080, 1'b1, e);
      sb.push_back(e);
      send_frame(-1);

      build_std(11'($urandom), 1'b0, 4'd2, {$urandom, $urandom}, 15'h0, 1'b1, e);
      sb.push_back(e);
      send_frame(-1);

      build_std(11'($urandom), 1'b0, 4'd15, {$urandom, $urandom}, 15'h0, 1'b1, e);
      sb.push_back(e);
      send_frame(-1);

      build_std(11'($urandom), 1'b1, 4'd4, 64'h0, 15'h0, 1'b1, e);
      sb.push_back(e);
      send_frame(-1);

      build_std(11'($urandom), 1'b0, 4'd4, {$urandom, $urandom}, 15'h0, 1'b1, e);
      send_frame(29);
      repeat (10) @(posedge clk);
      build_std(11'h000, 1'b0, 4'd0, 64'h0, 15'h0, 1'b1, e);
      sb.push_back(e);
      send_frame(-1);

      build_std(11'($urandom), 1'b0, 4'd1, {$urandom, $urandom}, 15'h0, 1'b0, e);
      sb.push_back(e);
      send_frame(-1);

`ifdef CAN_EXT_ID_EN
      fb.delete();
      ff.delete();
      add(1'b0, 3'd1);
      for (int i = 0; i < 11; i++) add(1'b0, 3'd1);
      add(1'b1, 3'd2);
      add(1'b1, 3'd6);
      for (int i = 0; i < 18; i++) add(1'b0, 3'd6);
      add(1'b0, 3'd6);
      add(1'b0, 3'd2);
      add(1'b0, 3'd2);
      for (int i = 3; i >= 0; i--) add(1'b0, (i == 0) ? 3'd4 : 3'd2);
      begin
         logic [14:0] c;
         c = '0;
         foreach (fb[i]) c = crc_step(c, fb[i]);
         e.en_cnt = fb.size();
         for (int i = 14; i >= 0; i--) add(c[i], (i == 0) ? 3'd5 : 3'd4);
      end
      add(1'b1, 3'd0);
      e.kind = 3'b001;
      e.dlc = 4'd0;
      e.rtr = 1'b0;
      e.chk_dlc = 1'b1;
      sb.push_back(e);
      send_frame(-1);
`else
      fb.delete();
      ff.delete();
      add(1'b0, 3'd1);
      for (int i = 0; i < 11; i++) add(1'($urandom), 3'd1);
      add(1'b0, 3'd2);
      add(1'b1, 3'd0);
      e.kind = 3'b100;
      e.en_cnt = 14;
      e.dlc = 4'd0;
      e.rtr = 1'b0;
      e.chk_dlc = 1'b0;
      sb.push_back(e);
      send_frame(-1);
`endif

      for (int n = 0; n < 25; n++) begin
         logic [14:0] flip;
         flip = ($urandom_range(0, 2) == 0) ? (15'd1 << $urandom_range(0, 14)) : 15'd0;
         build_std(11'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
                   {$urandom, $urandom}, flip, ($urandom_range(0, 7) != 0), e);
         sb.push_back(e);
         send_frame(-1);
      end

      for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
      chk("scoreboard_drained", longint'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
